// File: rtl/systolic_result_drain_if.sv
// Result-drain bus: skewed per-row inputs from the PE array's right edge and the
// deskewed valid/ready result stream towards downstream logic.
interface systolic_result_drain_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4
);
  logic [ROWS*WIDTH-1:0] in_sum;
  logic [ROWS-1:0]       in_valid;
  logic [ROWS-1:0]       in_ovf;
  logic [ROWS*WIDTH-1:0] out_data;
  logic [ROWS-1:0]       out_ovf;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_sum, in_valid, in_ovf, out_ready,
    input  out_data, out_ovf, out_valid
  );

  modport slave (
    input  in_sum, in_valid, in_ovf, out_ready,
    output out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Deskews the staggered right-edge row outputs of the systolic array, checks
// vector alignment and queues complete result vectors in a small FIFO.
module systolic_result_drain #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_result_drain_if.slave  bus,
  input  logic                    clr_status,
  output logic [ROWS-1:0]         ovf_sticky,
  output logic                    drop_sticky,
  output logic                    misalign_sticky,
  output logic [31:0]             vec_count,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ROWS*WIDTH + ROWS;
  localparam int STG_W = WIDTH + 2;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ROWS*WIDTH-1:0] al_sum;
  logic [ROWS-1:0]       al_valid;
  logic [ROWS-1:0]       al_ovf;

  // Row gi needs ROWS-gi stages so every row of a vector lands in the same cycle.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    localparam int NSTG = ROWS - gi;
    logic [STG_W-1:0] stg_q [NSTG];
    logic [STG_W-1:0] stg_d [NSTG];

    always_comb begin
      stg_d[0] = {bus.in_valid[gi], bus.in_ovf[gi], bus.in_sum[gi*WIDTH +: WIDTH]};
      for (int k = 1; k < NSTG; k++) begin
        stg_d[k] = stg_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < NSTG; k++) stg_q[k] <= '0;
      end else begin
        for (int k = 0; k < NSTG; k++) stg_q[k] <= stg_d[k];
      end
    end

    assign al_valid[gi]                = stg_q[NSTG-1][STG_W-1];
    assign al_ovf[gi]                  = stg_q[NSTG-1][STG_W-2];
    assign al_sum[gi*WIDTH +: WIDTH]   = stg_q[NSTG-1][WIDTH-1:0];
  end

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [ROWS-1:0]  ovf_sticky_q, ovf_sticky_d;
  logic             drop_sticky_q, drop_sticky_d;
  logic             misalign_sticky_q, misalign_sticky_d;
  logic [31:0]      vec_count_q, vec_count_d;

  logic all_valid, any_valid, empty, full;
  logic push, pop, drop, misalign;

  always_comb begin
    all_valid = &al_valid;
    any_valid = |al_valid;
    empty     = (level_q == '0);
    full      = (level_q == FULL_LVL);
    pop       = !empty && bus.out_ready;
    // A full FIFO still takes the vector when the head leaves in the same cycle.
    push      = all_valid && (!full || pop);
    drop      = all_valid && !push;
    misalign  = any_valid && !all_valid;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    ovf_sticky_d      = ovf_sticky_q;
    drop_sticky_d     = drop_sticky_q;
    misalign_sticky_d = misalign_sticky_q;
    vec_count_d       = vec_count_q;
    if (clr_status) begin
      ovf_sticky_d      = '0;
      drop_sticky_d     = 1'b0;
      misalign_sticky_d = 1'b0;
      vec_count_d       = '0;
    end else begin
      if (push) begin
        ovf_sticky_d = ovf_sticky_q | al_ovf;
        vec_count_d  = vec_count_q + 32'd1;
      end
      if (drop)     drop_sticky_d     = 1'b1;
      if (misalign) misalign_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      level_q           <= '0;
      ovf_sticky_q      <= '0;
      drop_sticky_q     <= 1'b0;
      misalign_sticky_q <= 1'b0;
      vec_count_q       <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      level_q           <= level_d;
      ovf_sticky_q      <= ovf_sticky_d;
      drop_sticky_q     <= drop_sticky_d;
      misalign_sticky_q <= misalign_sticky_d;
      vec_count_q       <= vec_count_d;
    end
  end

  // Storage is never reset; the level gate keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {al_ovf, al_sum};
  end

  logic [ENT_W-1:0] head;
  assign head          = fifo_mem[rd_ptr_q];
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[ROWS*WIDTH-1:0];
  assign bus.out_ovf   = empty ? '0 : head[ENT_W-1 -: ROWS];

  assign ovf_sticky      = ovf_sticky_q;
  assign drop_sticky     = drop_sticky_q;
  assign misalign_sticky = misalign_sticky_q;
  assign vec_count       = vec_count_q;
  assign fifo_level      = level_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench: skews whole vectors onto the rows like the PE array would and
// checks deskew latency, ordering, backpressure, drops, misalignment and status.
module tb_systolic_result_drain;
  localparam int WIDTH = 16;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr_status;
  logic [ROWS-1:0] ovf_sticky;
  logic drop_sticky;
  logic misalign_sticky;
  logic [31:0] vec_count;
  logic [$clog2(DEPTH):0] fifo_level;

  int total = 0;
  int bad   = 0;
  int rx;

  always #5 clk = ~clk;

  systolic_result_drain_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

  systolic_result_drain #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .clr_status      (clr_status),
    .ovf_sticky      (ovf_sticky),
    .drop_sticky     (drop_sticky),
    .misalign_sticky (misalign_sticky),
    .vec_count       (vec_count),
    .fifo_level      (fifo_level)
  );

  // History of presented vectors; row r is driven from the vector sent r cycles ago.
  logic [ROWS*WIDTH-1:0] h_sum [ROWS];
  logic [ROWS-1:0]       h_val [ROWS];
  logic [ROWS-1:0]       h_ovf [ROWS];

  task automatic clear_hist();
    for (int k = 0; k < ROWS; k++) begin
      h_sum[k] = '0;
      h_val[k] = '0;
      h_ovf[k] = '0;
    end
  endtask

  task automatic send(input logic [ROWS*WIDTH-1:0] d, input logic [ROWS-1:0] m,
                      input logic [ROWS-1:0] o);
    for (int k = ROWS-1; k > 0; k--) begin
      h_sum[k] = h_sum[k-1];
      h_val[k] = h_val[k-1];
      h_ovf[k] = h_ovf[k-1];
    end
    h_sum[0] = d;
    h_val[0] = m;
    h_ovf[0] = o;
    for (int r = 0; r < ROWS; r++) begin
      bus.in_sum[r*WIDTH +: WIDTH] = h_sum[r][r*WIDTH +: WIDTH];
      bus.in_valid[r]              = h_val[r][r];
      bus.in_ovf[r]                = h_ovf[r][r];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send('0, '0, '0);
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
  endtask

  function automatic logic [ROWS*WIDTH-1:0] mkvec(input int i);
    logic [ROWS*WIDTH-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*WIDTH +: WIDTH] = 16'(100*i + r + 1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr_status = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_sum = '0;
    bus.in_valid = '0;
    bus.in_ovf = '0;
    clear_hist();
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_drop", 64'(drop_sticky), 64'd0);
    chk("rst_misalign", 64'(misalign_sticky), 64'd0);
    chk("rst_count", 64'(vec_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);

    // Single skewed vector {40,30,20,10}: visible ROWS+1 cycles after row 0
    send(64'h0028_001E_0014_000A, 4'hF, 4'h0);
    idle(3);
    chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
    idle(1);
    $display("single vector: valid=%0d data=%h", bus.out_valid, bus.out_data);
    chk("one_valid", 64'(bus.out_valid), 64'd1);
    chk("one_data", bus.out_data, 64'h0028_001E_0014_000A);
    chk("one_ovf", 64'(bus.out_ovf), 64'd0);
    chk("one_count", 64'(vec_count), 64'd1);
    chk("one_level", 64'(fifo_level), 64'd1);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    chk("one_pop_level", 64'(fifo_level), 64'd0);
    chk("one_pop_data", bus.out_data, 64'd0);

    // Streaming 8 vectors with out_ready held high
    clr_pulse();
    chk("clr_count", 64'(vec_count), 64'd0);
    bus.out_ready = 1'b1;
    rx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) send(mkvec(cyc), 4'hF, 4'h0);
      else         idle(1);
      chk("stream_level_le1", 64'(fifo_level <= 1), 64'd1);
      chk("stream_valid", 64'(bus.out_valid), 64'(cyc >= 4 && cyc < 12));
      if (bus.out_valid) begin
        $display("stream rx %0d: data=%h", rx, bus.out_data);
        chk("stream_data", bus.out_data, mkvec(rx));
        rx++;
      end
    end
    chk("stream_rx", 64'(rx), 64'd8);
    chk("stream_drop", 64'(drop_sticky), 64'd0);
    chk("stream_count", 64'(vec_count), 64'd8);
    bus.out_ready = 1'b0;

    // Backpressure: 6 vectors into a 4-deep FIFO
    clr_pulse();
    for (int i = 0; i < 6; i++) send(mkvec(20 + i), 4'hF, 4'h0);
    idle(5);
    chk("bp_level", 64'(fifo_level), 64'd4);
    chk("bp_drop", 64'(drop_sticky), 64'd1);
    chk("bp_count", 64'(vec_count), 64'd4);
    chk("bp_head", bus.out_data, mkvec(20));
    idle(2);
    chk("bp_stable", bus.out_data, mkvec(20));
    chk("bp_stable_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("drain %0d: data=%h", k, bus.out_data);
      chk("bp_drain", bus.out_data, mkvec(20 + k));
      idle(1);
    end
    bus.out_ready = 1'b0;
    chk("bp_empty_level", 64'(fifo_level), 64'd0);
    chk("bp_empty_valid", 64'(bus.out_valid), 64'd0);

    // Full FIFO, push and pop in the same cycle
    clr_pulse();
    chk("full_drop_cleared", 64'(drop_sticky), 64'd0);
    for (int i = 0; i < 4; i++) send(mkvec(30 + i), 4'hF, 4'h0);
    idle(5);
    chk("full_level", 64'(fifo_level), 64'd4);
    send(mkvec(34), 4'hF, 4'h0);
    idle(3);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_drop", 64'(drop_sticky), 64'd0);
    chk("pp_count", 64'(vec_count), 64'd5);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("pp drain %0d: data=%h", k, bus.out_data);
      chk("pp_drain", bus.out_data, mkvec(31 + k));
      idle(1);
    end
    bus.out_ready = 1'b0;

    // Misalignment: row 2 missing
    chk("mis_before", 64'(misalign_sticky), 64'd0);
    send(mkvec(40), 4'b1011, 4'h0);
    idle(5);
    chk("mis_flag", 64'(misalign_sticky), 64'd1);
    chk("mis_count", 64'(vec_count), 64'd5);
    chk("mis_level", 64'(fifo_level), 64'd0);
    send(mkvec(41), 4'hF, 4'h0);
    idle(5);
    chk("mis_next_valid", 64'(bus.out_valid), 64'd1);
    chk("mis_next_data", bus.out_data, mkvec(41));
    chk("mis_next_count", 64'(vec_count), 64'd6);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;

    // Overflow carried with the vector, then cleared from the status
    send(mkvec(50), 4'hF, 4'b0010);
    idle(5);
    chk("ovf_out", 64'(bus.out_ovf), 64'b0010);
    chk("ovf_sticky", 64'(ovf_sticky), 64'b0010);
    clr_pulse();
    chk("clr_ovf_sticky", 64'(ovf_sticky), 64'd0);
    chk("clr_misalign", 64'(misalign_sticky), 64'd0);
    chk("clr_vec_count", 64'(vec_count), 64'd0);
    chk("clr_keeps_level", 64'(fifo_level), 64'd1);
    chk("clr_keeps_ovf", 64'(bus.out_ovf), 64'b0010);

    // clr_status in the push cycle: entry stored, event not recorded
    send(mkvec(51), 4'hF, 4'b1000);
    idle(3);
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    chk("coll_count", 64'(vec_count), 64'd0);
    chk("coll_ovf_sticky", 64'(ovf_sticky), 64'd0);
    chk("coll_level", 64'(fifo_level), 64'd2);

    // Reset with two entries queued
    rst = 1'b1;
    clear_hist();
    idle(1);
    rst = 1'b0;
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_level", 64'(fifo_level), 64'd0);
    chk("rst2_data", bus.out_data, 64'd0);

    // Reset while a vector is inside the deskew stages
    send(mkvec(60), 4'hF, 4'h0);
    rst = 1'b1;
    clear_hist();
    idle(1);
    rst = 1'b0;
    idle(6);
    chk("rst3_valid", 64'(bus.out_valid), 64'd0);
    chk("rst3_count", 64'(vec_count), 64'd0);
    chk("rst3_misalign", 64'(misalign_sticky), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
